// File: rtl/qracc_csr_sequencer.sv
// CSR run sequencer: writes CONFIG, kicks START, polls STATUS.busy with a gap, then writes STOP.
// Optional poll timeout with abort via CLEAR write: define QRACC_SEQ_TIMEOUT_EN.
module qracc_csr_sequencer #(
   parameter int ADDR_W        = 2,
   parameter int POLL_GAP      = 4,
   parameter int TIMEOUT_POLLS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_valid,
   output logic              run_ready,
   input  logic [31:0]       run_cfg,
   output logic              m_valid,
   output logic              m_wen,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_data,
   input  logic              m_ready,
   input  logic [31:0]       m_read_data,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [15:0]       poll_cnt_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WR_CFG   = 3'd1;
   localparam logic [2:0] S_WR_START = 3'd2;
   localparam logic [2:0] S_GAP      = 3'd3;
   localparam logic [2:0] S_POLL     = 3'd4;
   localparam logic [2:0] S_WR_STOP  = 3'd5;
   localparam logic [2:0] S_WR_CLEAR = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   localparam logic [7:0] LP_GAP = 8'(POLL_GAP);

   logic [2:0]  r_state;
   logic [31:0] r_cfg;
   logic [15:0] r_cnt;
   logic [7:0]  r_gap;
   logic [15:0] w_cnt_inc;
   logic [2:0]  w_after_hs;
   logic        w_hs;
   logic        w_unused;

   assign w_hs       = m_valid && m_ready;
   assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   // A zero gap skips the GAP state entirely
   assign w_after_hs = (LP_GAP == 8'd0) ? S_POLL : S_GAP;
   assign w_unused   = &{1'b0, m_read_data[31:2], m_read_data[0], 16'(TIMEOUT_POLLS)};

   assign run_ready  = (r_state == S_IDLE);
   assign busy_o     = (r_state != S_IDLE);
   assign done_o     = (r_state == S_DONE);
   assign poll_cnt_o = r_cnt;

   // Request fields are pure functions of state, so they stay stable while stalled
   always_comb begin
      m_valid = 1'b0;
      m_wen   = 1'b0;
      m_addr  = '0;
      m_data  = 32'h0;
      case (r_state)
         S_WR_CFG:   begin m_valid = 1'b1; m_wen = 1'b1; m_addr = ADDR_W'(1); m_data = r_cfg; end
         S_WR_START: begin m_valid = 1'b1; m_wen = 1'b1; m_data = 32'h0000_0001; end
         S_POLL:     begin m_valid = 1'b1; end
         S_WR_STOP:  begin m_valid = 1'b1; m_wen = 1'b1; end
         S_WR_CLEAR: begin m_valid = 1'b1; m_wen = 1'b1; m_data = 32'h0000_0004; end
         default:    ;
      endcase
   end

`ifdef QRACC_SEQ_TIMEOUT_EN
   localparam logic [15:0] LP_TO = 16'(TIMEOUT_POLLS);
   logic r_err;
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cfg   <= 32'h0;
         r_cnt   <= 16'h0;
         r_gap   <= 8'h0;
`ifdef QRACC_SEQ_TIMEOUT_EN
         r_err   <= 1'b0;
`endif
      end else begin
`ifdef QRACC_SEQ_TIMEOUT_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: if (run_valid) begin
               r_cfg   <= run_cfg;
               r_cnt   <= 16'h0;
               r_state <= S_WR_CFG;
            end
            S_WR_CFG: if (w_hs) r_state <= S_WR_START;
            S_WR_START: if (w_hs) begin
               r_gap   <= 8'h0;
               r_state <= w_after_hs;
            end
            S_GAP: begin
               if (r_gap == LP_GAP - 8'd1) r_state <= S_POLL;
               else                        r_gap   <= r_gap + 8'd1;
            end
            S_POLL: if (w_hs) begin
               r_cnt <= w_cnt_inc;
               r_gap <= 8'h0;
               if (!m_read_data[1])             r_state <= S_WR_STOP;
`ifdef QRACC_SEQ_TIMEOUT_EN
               else if (w_cnt_inc >= LP_TO)     r_state <= S_WR_CLEAR;
`endif
               else                             r_state <= w_after_hs;
            end
            S_WR_STOP: if (w_hs) r_state <= S_DONE;
            S_WR_CLEAR: if (w_hs) begin
`ifdef QRACC_SEQ_TIMEOUT_EN
               r_err   <= 1'b1;
`endif
               r_state <= S_IDLE;
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qracc_csr_sequencer.sv
// Scoreboard bench for qracc_csr_sequencer (default build): expected CSR transfers are queued
// per run and popped as the responder model accepts them.
module tb_qracc_csr_sequencer;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run_valid = 1'b0;
   logic          run_ready;
   logic [31:0]   run_cfg = 32'h0;
   logic          m_valid, m_wen;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_data;
   logic          m_ready = 1'b0;
   logic [31:0]   m_read_data = 32'h0;
   logic          busy_o, done_o, err_o;
   logic [15:0]   poll_cnt_o;

   qracc_csr_sequencer #(.ADDR_W(AW), .POLL_GAP(4), .TIMEOUT_POLLS(1024)) dut (
      .clk(clk), .rst(rst), .run_valid(run_valid), .run_ready(run_ready), .run_cfg(run_cfg),
      .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_data(m_data),
      .m_ready(m_ready), .m_read_data(m_read_data),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .poll_cnt_o(poll_cnt_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   logic [34:0] exp_q[$];
   int cyc = 0, busy_left = 0, stall_left = 0, stall_seen = 0, npolls = 0, n_err = 0, prev_cyc = 0;
   bit stall_on = 0, force_nready = 0, stuck_mode = 0, prev_ok = 0;
   logic [31:0] stall_data = 32'h0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Responder model and bus monitor; everything seen here is what the next posedge samples
   always @(negedge clk) begin
      logic [34:0] txn;
      logic [31:0] rd;
      cyc++;
      if (err_o) n_err++;
      if (rst) begin
         m_ready  = 1'b0;
         stall_on = 1'b0;
      end else begin
         if (stall_left > 0 && (stall_on || (m_valid && m_wen && m_addr == AW'(1)))) begin
            stall_on = 1'b1;
            chk("stall_valid", 64'(m_valid), 1);
            chk("stall_addr", 64'(m_addr), 1);
            chk("stall_data", 64'(m_data), 64'(stall_data));
            stall_left--;
            stall_seen++;
            m_ready = 1'b0;
         end else begin
            stall_on = 1'b0;
            m_ready  = !force_nready;
         end
         rd = $urandom;
         rd[1] = m_ready ? (busy_left > 0) : 1'($urandom);
         m_read_data = rd;
         if (m_valid && m_ready) begin
            txn = {m_wen, m_addr, m_data};
            if (exp_q.size() > 0)  chk("bus_txn", 64'(txn), 64'(exp_q.pop_front()));
            else if (stuck_mode)   chk("bus_poll", 64'(txn), 64'h0);
            else                   chk("bus_unexpected", 64'(txn), 64'h7FFFFFFFF);
            if (!m_wen) begin
               if (prev_ok) chk("poll_gap", 64'(cyc - prev_cyc - 1), 4);
               npolls++;
               if (busy_left > 0) busy_left--;
            end
            prev_ok  = !m_wen || (m_addr == '0 && m_data == 32'h1);
            prev_cyc = cyc;
         end
      end
   end

   task automatic push_run(input logic [31:0] cfg, input int nb);
      exp_q.push_back({1'b1, 2'd1, cfg});
      exp_q.push_back({1'b1, 2'd0, 32'h1});
      for (int i = 0; i <= nb; i++) exp_q.push_back({1'b0, 2'd0, 32'h0});
      exp_q.push_back({1'b1, 2'd0, 32'h0});
   endtask

   task automatic start_run(input logic [31:0] cfg, input bit hold);
      int t = 0;
      @(negedge clk);
      while (!run_ready && t < 100) begin @(negedge clk); t++; end
      if (!run_ready) chk("accept_timeout", 0, 1);
      run_valid = 1'b1;
      run_cfg   = cfg;
      @(negedge clk);
      if (!hold) run_valid = 1'b0;
      chk("busy_after_accept", 64'(busy_o), 1);
      chk("cnt_zeroed", 64'(poll_cnt_o), 0);
   endtask

   task automatic wait_done(input int exp_cnt, input bit expect_empty);
      int t = 0;
      while (!done_o && t < 3000) begin @(negedge clk); t++; end
      if (!done_o) chk("done_timeout", 0, 1);
      else begin
         chk("done_no_ready", 64'(run_ready), 0);
         chk("done_poll_cnt", 64'(poll_cnt_o), 64'(exp_cnt));
         @(negedge clk);
         chk("done_pulse", 64'(done_o), 0);
         chk("idle_ready", 64'(run_ready), 1);
         chk("idle_busy", 64'(busy_o), 0);
         if (expect_empty) chk("sb_empty", 64'(exp_q.size()), 0);
      end
   endtask

   initial begin
      logic [31:0] c1, c2;
      int nb, t;
      repeat (3) @(negedge clk);
      chk("rst_m_valid", 64'(m_valid), 0);
      chk("rst_m_wen", 64'(m_wen), 0);
      chk("rst_m_addr", 64'(m_addr), 0);
      chk("rst_m_data", 64'(m_data), 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_done", 64'(done_o), 0);
      chk("rst_err", 64'(err_o), 0);
      chk("rst_cnt", 64'(poll_cnt_o), 0);
      chk("rst_ready", 64'(run_ready), 1);
      rst = 1'b0;

      // Basic run: busy for two polls, cleared on the third
      busy_left = 2;
      push_run(32'h35, 2);
      start_run(32'h35, 0);
      wait_done(3, 1);
      repeat (3) @(negedge clk);
      chk("cnt_hold_idle", 64'(poll_cnt_o), 3);

      // Responder stalls the CONFIG write for five cycles
      stall_left = 5; stall_data = 32'h35; stall_seen = 0; busy_left = 0;
      push_run(32'h35, 0);
      start_run(32'h35, 0);
      wait_done(1, 1);
      chk("stall_cycles", 64'(stall_seen), 5);

      for (int k = 0; k < 3; k++) begin
         c1 = $urandom; nb = $urandom_range(0, 3);
         busy_left = nb;
         push_run(c1, nb);
         start_run(c1, 0);
         wait_done(nb + 1, 1);
      end

      // run_valid held through a run: next accept only after DONE
      c1 = $urandom; c2 = $urandom;
      busy_left = 1;
      push_run(c1, 1);
      push_run(c2, 0);
      start_run(c1, 1);
      run_cfg = c2;
      wait_done(2, 0);
      @(negedge clk);
      run_valid = 1'b0;
      chk("b2b_busy", 64'(busy_o), 1);
      chk("b2b_cnt", 64'(poll_cnt_o), 0);
      wait_done(1, 1);

      // Busy stuck: polling continues past 100, then reset while a poll is stalled
      stuck_mode = 1; busy_left = 1000000; npolls = 0;
      c1 = $urandom;
      exp_q.push_back({1'b1, 2'd1, c1});
      exp_q.push_back({1'b1, 2'd0, 32'h1});
      start_run(c1, 0);
      t = 0;
      while (npolls <= 100 && t < 3000) begin @(negedge clk); t++; end
      chk("polls_past_100", 64'(npolls > 100), 1);
      @(negedge clk);
      chk("cnt_past_100", 64'(poll_cnt_o > 100), 1);
      chk("still_busy", 64'(busy_o), 1);
      force_nready = 1;
      t = 0;
      @(negedge clk);
      while (!m_valid && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      @(negedge clk);
      chk("stalled_poll", 64'(m_valid && !m_wen), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 64'(m_valid), 0);
      chk("mid_rst_busy", 64'(busy_o), 0);
      chk("mid_rst_ready", 64'(run_ready), 1);
      chk("mid_rst_cnt", 64'(poll_cnt_o), 0);
      rst = 1'b0;
      exp_q.delete();
      stuck_mode = 0; force_nready = 0; busy_left = 0;
      repeat (5) @(negedge clk);

      busy_left = 2;
      push_run(32'h35, 2);
      start_run(32'h35, 0);
      wait_done(3, 1);

      chk("err_never", 64'(n_err), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
